// File: rtl/cmp_pkg.sv
// Shared definitions for the compare sequencer: opcode encodings and FSM states.
package cmp_pkg;

  // Compare opcodes, applied as (A op B) with A = sample, B = rule threshold.
  localparam logic [2:0] OP_GT     = 3'd0;
  localparam logic [2:0] OP_GTE    = 3'd1;
  localparam logic [2:0] OP_EQ     = 3'd2;
  localparam logic [2:0] OP_LT     = 3'd3;
  localparam logic [2:0] OP_LTE    = 3'd4;
  localparam logic [2:0] OP_NEVER  = 3'd5;
  localparam logic [2:0] OP_ALWAYS = 3'd6;
  localparam logic [2:0] OP_NEQ    = 3'd7;

  // Largest rule table the 3-bit config address can reach.
  localparam int MAX_RULES = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_8bit.sv
// Combinational unsigned 8-bit comparator with opcode select and enable gate.
module comparator_8bit
  import cmp_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] opcode,
  input  logic       enable,
  output logic       result
);

  // Evaluate the selected relation; a disabled compare always reports 0.
  always_comb begin
    result = 1'b0;
    if (enable) begin
      case (opcode)
        OP_GT:     result = (a >  b);
        OP_GTE:    result = (a >= b);
        OP_EQ:     result = (a == b);
        OP_LT:     result = (a <  b);
        OP_LTE:    result = (a <= b);
        OP_NEVER:  result = 1'b0;
        OP_ALWAYS: result = 1'b1;
        OP_NEQ:    result = (a != b);
        default:   result = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/compare_sequencer.sv
// Time-shares one comparator across a programmable rule table, one rule per
// cycle, and returns a per-rule match mask with any/all summaries.
module compare_sequencer
  import cmp_pkg::*;
#(
  parameter int NUM_RULES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [2:0]           cfg_opcode,
  input  logic [7:0]           cfg_thresh,
  input  logic                 cfg_en,
  output logic                 cfg_busy,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [7:0]           sample_data,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [NUM_RULES-1:0] match_mask,
  output logic                 match_any,
  output logic                 match_all
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_RULES - 1);

  state_t               state;
  logic [7:0]           a_reg;
  logic [2:0]           idx;
  logic [2:0]           op_tbl [NUM_RULES];
  logic [7:0]           th_tbl [NUM_RULES];
  logic [NUM_RULES-1:0] en_tbl;

  logic [2:0]           cur_op;
  logic [7:0]           cur_th;
  logic                 cur_en;
  logic                 cmp_res;
  logic [NUM_RULES-1:0] next_mask;

  logic                 accept;

  assign accept       = (state == IDLE) && sample_valid;
  assign sample_ready = (state == IDLE);
  assign cfg_busy     = (state != IDLE);
  assign result_valid = (state == DONE);

  // Select the rule addressed by idx; the loop keeps the index within the table.
  always_comb begin
    cur_op = OP_NEVER;
    cur_th = 8'h00;
    cur_en = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (idx == 3'(i)) begin
        cur_op = op_tbl[i];
        cur_th = th_tbl[i];
        cur_en = en_tbl[i];
      end
    end
  end

  comparator_8bit u_cmp (
    .a      (a_reg),
    .b      (cur_th),
    .opcode (cur_op),
    .enable (cur_en),
    .result (cmp_res)
  );

  // Merge the current rule's result into the mask bit it owns.
  always_comb begin
    next_mask = match_mask;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (idx == 3'(i)) next_mask[i] = cmp_res;
    end
  end

  // Sample operand register; only meaningful from accept until the next accept.
  always_ff @(posedge clk) begin
    if (accept) a_reg <= sample_data;
  end

  // Sequencer FSM, rule table writes and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      match_mask <= '0;
      match_any  <= 1'b0;
      match_all  <= 1'b0;
      en_tbl     <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        op_tbl[i] <= 3'd0;
        th_tbl[i] <= 8'h00;
      end
    end else begin
      case (state)
        IDLE: begin
          // Table is only writable while idle; out-of-range addresses match no entry.
          if (cfg_we) begin
            for (int i = 0; i < NUM_RULES; i++) begin
              if (cfg_addr == 3'(i)) begin
                op_tbl[i] <= cfg_opcode;
                th_tbl[i] <= cfg_thresh;
                en_tbl[i] <= cfg_en;
              end
            end
          end
          if (sample_valid) begin
            match_mask <= '0;
            idx        <= 3'd0;
            state      <= EVAL;
          end
        end
        EVAL: begin
          match_mask <= next_mask;
          if (idx == LAST_IDX) begin
            // Summaries are refreshed only when a complete result is ready.
            match_any <= |next_mask;
            match_all <= (|en_tbl) && ((next_mask & en_tbl) == en_tbl);
            state     <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_compare_sequencer.sv
// Scoreboard bench for compare_sequencer: directed scenarios plus random
// config/sample traffic checked against a rule-table reference model.
module tb_compare_sequencer;
  import cmp_pkg::*;

  localparam int NUM_RULES = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_we = 1'b0;
  logic [2:0]           cfg_addr = '0;
  logic [2:0]           cfg_opcode = '0;
  logic [7:0]           cfg_thresh = '0;
  logic                 cfg_en = 1'b0;
  logic                 cfg_busy;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready;
  logic [7:0]           sample_data = '0;
  logic                 result_valid;
  logic                 result_ready = 1'b1;
  logic [NUM_RULES-1:0] match_mask;
  logic                 match_any;
  logic                 match_all;

  compare_sequencer #(.NUM_RULES(NUM_RULES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_opcode   (cfg_opcode),
    .cfg_thresh   (cfg_thresh),
    .cfg_en       (cfg_en),
    .cfg_busy     (cfg_busy),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .match_mask   (match_mask),
    .match_any    (match_any),
    .match_all    (match_all)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_RULES-1:0] mask;
    logic                 any;
    logic                 all;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  res_t sb[$];

  logic [2:0] m_op [NUM_RULES];
  logic [7:0] m_th [NUM_RULES];
  logic       m_en [NUM_RULES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NUM_RULES; i++) begin
      m_op[i] = 3'd0;
      m_th[i] = 8'h00;
      m_en[i] = 1'b0;
    end
  endfunction

  // Expected result of one sample against the current rule table.
  function automatic res_t model(input logic [7:0] d);
    res_t r;
    int   nen;
    int   nhit;
    bit   hit;
    r    = '0;
    nen  = 0;
    nhit = 0;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (m_en[i]) begin
        nen++;
        case (m_op[i])
          OP_GT:     hit = (d >  m_th[i]);
          OP_GTE:    hit = (d >= m_th[i]);
          OP_EQ:     hit = (d == m_th[i]);
          OP_LT:     hit = (d <  m_th[i]);
          OP_LTE:    hit = (d <= m_th[i]);
          OP_NEVER:  hit = 0;
          OP_ALWAYS: hit = 1;
          default:   hit = (d != m_th[i]);
        endcase
        if (hit) begin
          r.mask[i] = 1'b1;
          nhit++;
        end
      end
    end
    r.any = (nhit > 0);
    r.all = (nen > 0) && (nhit == nen);
    return r;
  endfunction

  // Write one rule while idle; the model keeps only in-range addresses.
  task automatic cfg_write(input logic [2:0] addr, input logic [2:0] op,
                           input logic [7:0] th, input logic en);
    cfg_we     = 1'b1;
    cfg_addr   = addr;
    cfg_opcode = op;
    cfg_thresh = th;
    cfg_en     = en;
    check("cfg_busy_idle", cfg_busy, 0);
    if (int'(addr) < NUM_RULES) begin
      m_op[addr] = op;
      m_th[addr] = th;
      m_en[addr] = en;
    end
    step();
    cfg_we = 1'b0;
  endtask

  // Offer a sample, wait for acceptance and record the expected result.
  task automatic issue(input logic [7:0] d);
    int n;
    n = 0;
    sample_data  = d;
    sample_valid = 1'b1;
    while (!sample_ready && n < 50) begin
      step();
      n++;
    end
    if (!sample_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      sb.push_back(model(d));
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!result_valid && lat < 50) begin
      step();
      lat++;
    end
    if (!result_valid) check("result_timeout", 0, 1);
  endtask

  // Full transaction with optional back-pressure of 'hold' cycles.
  task automatic send(input logic [7:0] d, input int hold);
    int lat;
    result_ready = (hold == 0);
    issue(d);
    wait_valid(lat);
    repeat (hold) step();
    result_ready = 1'b1;
    step();
  endtask

  // Monitor: compare every accepted result against the scoreboard head.
  initial begin
    res_t exp_r;
    res_t act_r;
    forever begin
      @(negedge clk);
      if (rst_n && result_valid && result_ready) begin
        act_r = '{mask: match_mask, any: match_any, all: match_all};
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(act_r), 32'hFFFF_FFFF);
        end else begin
          exp_r = sb.pop_front();
          check("result", 32'(act_r), 32'(exp_r));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t1;
    int t2;
    model_clear();

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("rst_sample_ready", sample_ready, 1);
    check("rst_result_valid", result_valid, 0);
    check("rst_mask", 32'(match_mask), 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_any_all", {match_any, match_all}, 0);

    // Programmed table, sample 0x55, latency
    cfg_write(3'd0, OP_GT, 8'h40, 1'b1);
    cfg_write(3'd1, OP_EQ, 8'h55, 1'b1);
    cfg_write(3'd2, OP_LT, 8'h10, 1'b1);
    cfg_write(3'd3, OP_ALWAYS, 8'h00, 1'b1);
    result_ready = 1'b1;
    issue(8'h55);
    wait_valid(lat);
    check("latency", lat, NUM_RULES);
    check("mask_1011", 32'(match_mask), 32'b1011);
    check("any_1011", match_any, 1);
    check("all_1011", match_all, 0);
    step();

    // Rules 2,3 disabled
    cfg_write(3'd2, OP_LT, 8'h10, 1'b0);
    cfg_write(3'd3, OP_ALWAYS, 8'h00, 1'b0);
    issue(8'h55);
    wait_valid(lat);
    check("mask_0011", 32'(match_mask), 32'b0011);
    check("all_0011", match_all, 1);
    step();

    // All rules disabled
    cfg_write(3'd0, OP_GT, 8'h40, 1'b0);
    cfg_write(3'd1, OP_EQ, 8'h55, 1'b0);
    issue(8'h55);
    wait_valid(lat);
    check("mask_none", 32'(match_mask), 0);
    check("any_all_none", {match_any, match_all}, 0);
    step();

    // Back-pressure hold
    cfg_write(3'd0, OP_GT, 8'h40, 1'b1);
    cfg_write(3'd1, OP_EQ, 8'h55, 1'b1);
    result_ready = 1'b0;
    issue(8'h55);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", result_valid, 1);
      check("hold_mask", 32'(match_mask), 32'b0011);
      check("hold_sample_ready", sample_ready, 0);
      step();
    end
    result_ready = 1'b1;
    step();
    check("release_valid", result_valid, 0);
    check("release_ready", sample_ready, 1);

    // Config write during EVAL is dropped
    issue(8'h55);
    cfg_we     = 1'b1;
    cfg_addr   = 3'd0;
    cfg_opcode = OP_NEVER;
    cfg_thresh = 8'h00;
    cfg_en     = 1'b1;
    check("busy_eval", cfg_busy, 1);
    step();
    cfg_we = 1'b0;
    wait_valid(lat);
    step();
    cfg_write(3'd5, OP_NEVER, 8'h00, 1'b1);
    send(8'h55, 0);
    send(8'h41, 0);

    // Same-cycle write and accept: new rule applies to this sample
    cfg_we       = 1'b1;
    cfg_addr     = 3'd1;
    cfg_opcode   = OP_EQ;
    cfg_thresh   = 8'h77;
    cfg_en       = 1'b1;
    m_op[1]      = OP_EQ;
    m_th[1]      = 8'h77;
    m_en[1]      = 1'b1;
    sample_data  = 8'h77;
    sample_valid = 1'b1;
    check("same_cycle_ready", sample_ready, 1);
    sb.push_back(model(8'h77));
    step();
    cfg_we       = 1'b0;
    sample_valid = 1'b0;
    wait_valid(lat);
    check("same_cycle_mask", 32'(match_mask), 32'b0011);
    step();

    // Throughput with back-to-back samples
    result_ready = 1'b1;
    issue(8'h30);
    t1 = cyc - 1;
    sample_data  = 8'h90;
    sample_valid = 1'b1;
    lat = 0;
    while (!sample_ready && lat < 50) begin
      step();
      lat++;
    end
    sb.push_back(model(8'h90));
    t2 = cyc;
    step();
    sample_valid = 1'b0;
    check("throughput", t2 - t1, NUM_RULES + 2);
    wait_valid(lat);
    step();

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      else
        send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end

    // Reset mid-EVAL
    for (int r = 0; r < NUM_RULES; r++) cfg_write(3'(r), OP_ALWAYS, 8'h00, 1'b1);
    send(8'h12, 0);
    check("pre_reset_any_all", {match_any, match_all}, 2'b11);
    sample_data  = 8'h34;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sample_ready", sample_ready, 1);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_busy", cfg_busy, 0);
    check("mid_rst_mask", 32'(match_mask), 0);
    check("mid_rst_any_all", {match_any, match_all}, 0);
    model_clear();
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_RULES + 3; i++) begin
      step();
      check("post_rst_no_valid", result_valid, 0);
    end
    send(8'hFF, 0);
    check("cleared_table_mask", 32'(match_mask), 0);

    repeat (3) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
